mem_dual_port_arbiter: RTL and testbench
========================================

Name: mem_dual_port_arbiter

Overview:
- Shares one dual-port word memory (one write port, one read port, 1-cycle registered read, write-to-read forwarding on same-address collision) between two requesters.
- M0 is the core data path; M1 is the loader/debug path.
- Issues at most one write and one read per cycle. When both masters need the same port type, it arbitrates round-robin.
- Tracks read ownership so each read response returns only to the master that issued it.

Parameters:
- DATA_WIDTH, 32, word width of the memory and both masters.
- ADDR_WIDTH, 32, word address width passed through unchanged.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  M0 access request, held until granted.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_WIDTH  word address.
- m0_wdata  in  DATA_WIDTH  write data.
- m0_gnt  out  1  request accepted this cycle.
- m0_rvalid  out  1  read data valid for M0.
- m0_rdata  out  DATA_WIDTH  read data for M0.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as M0, for M1.
- mem_wen  out  1  memory write enable.
- mem_waddr  out  ADDR_WIDTH  memory write address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ren  out  1  memory read enable.
- mem_raddr  out  ADDR_WIDTH  memory read address.
- mem_rdata  in  DATA_WIDTH  memory read data, valid 1 cycle after mem_ren.

Behaviour:
- Reset: asynchronous and active-low. While rst_n = 0:
  - rr_ptr = 0 (M0 wins the next conflict).
  - rd_tag_valid = 0, rd_tag_owner = 0.
  - m0_rvalid = m1_rvalid = 0.
  - gnt, mem_wen and mem_ren are forced to 0.
  - m*_rdata = 0.
- Grant logic is combinational and decided in the same cycle as req. Cases:
  - Only one req: granted.
  - Both req, one read and one write: both granted. The write goes to the write port, the read to the read port.
  - Both req, same type: the master selected by rr_ptr is granted; the other gets gnt = 0 and must hold its request.
- rr_ptr update at the clock edge, only on a same-type conflict: rr_ptr <= index of the loser. Otherwise rr_ptr holds.
- Port driving:
  - mem_wen = 1 and mem_waddr/mem_wdata come from the granted writer.
  - mem_ren = 1 and mem_raddr comes from the granted reader.
  - Unused address/data outputs are 0.
- Read tracking, registered at the clock edge:
  - rd_tag_valid <= mem_ren.
  - rd_tag_owner <= index of the granted reader.
- Read response, one cycle after grant:
  - m0_rvalid = rd_tag_valid & (owner == 0).
  - m1_rvalid = rd_tag_valid & (owner == 1).
  - The owner's m*_rdata = mem_rdata; the other master's m*_rdata = 0.
- Read latency: exactly 1 cycle from gnt to rvalid. Back-to-back reads from the same master are granted every cycle if uncontested, giving full throughput.
- Same-address write (M_a) plus read (M_b) in one cycle: both granted. The reader receives the new wdata next cycle through the memory's forwarding. The arbiter adds no extra handling.
- A master with req = 0 never receives gnt or rvalid, apart from a response to a read already granted.
- Reset asserted with a read in flight: rvalid drops immediately and the response is discarded. After release, the first conflict goes to M0.
- Address and data pass through unchanged; no width conversion or range checking.

Test Plan:
1. Reset, then M0 write addr 5 = 0xDEADBEEF (M1 idle) -> m0_gnt = 1, mem_wen = 1, mem_waddr = 5, mem_wdata = 0xDEADBEEF, same cycle. Next cycle M0 reads addr 5 -> m0_rvalid = 1 and m0_rdata = 0xDEADBEEF one cycle later; m1_rvalid stays 0.
2. Both masters read in the same cycle (M0 addr 1, M1 addr 2) for 4 consecutive cycles -> grants alternate M0, M1, M0, M1. rvalid alternates one cycle later with the correct per-owner data, and the non-owner's rdata = 0.
3. M0 writes addr 7 = 0x12345678 while M1 reads addr 7 in the same cycle -> both gnt = 1; next cycle m1_rvalid = 1, m1_rdata = 0x12345678.
4. Both masters write (M0 addr 3 = 0xA, M1 addr 3 = 0xB) with rr_ptr = 0 -> M0 granted first, M1 next cycle. A final read of addr 3 returns 0xB.
5. M1 read granted, then rst_n pulsed low mid-cycle before the next edge -> m1_rvalid = 0 immediately. After release, a both-read conflict grants M0 first.
6. M0 continuous uncontested reads of addr 0..7 -> gnt every cycle, rvalid on 8 consecutive cycles, data in order.

Source files
------------

// File: rtl/mem_dual_port_arbiter.sv
// Two-master arbiter in front of a dual-port word memory (one write port, one
// read port, 1-cycle registered read). Writes and reads are arbitrated
// independently; a same-type conflict is resolved round-robin. Read ownership
// is tagged so each response returns only to the master that issued the read.
module mem_dual_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic rr_q, rr_d;                      // index of the master that wins the next conflict
  logic rd_tag_valid_q, rd_tag_valid_d;
  logic rd_tag_owner_q, rd_tag_owner_d;

  logic wr0, wr1, rd0, rd1;
  logic w_conf, r_conf;
  logic w_sel, r_sel;                    // index of the granted writer / reader

  // Grant decision and memory port driving; everything is gated off in reset.
  always_comb begin
    wr0    = m0_req & m0_we;
    wr1    = m1_req & m1_we;
    rd0    = m0_req & ~m0_we;
    rd1    = m1_req & ~m1_we;
    w_conf = wr0 & wr1;
    r_conf = rd0 & rd1;
    // Without a conflict the selected index is simply whichever master asked.
    w_sel  = w_conf ? rr_q : wr1;
    r_sel  = r_conf ? rr_q : rd1;

    m0_gnt = rst_n & ((wr0 & ~w_sel) | (rd0 & ~r_sel));
    m1_gnt = rst_n & ((wr1 & w_sel) | (rd1 & r_sel));

    mem_wen   = rst_n & (wr0 | wr1);
    mem_ren   = rst_n & (rd0 | rd1);
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;
    if (mem_wen) begin
      mem_waddr = w_sel ? m1_addr  : m0_addr;
      mem_wdata = w_sel ? m1_wdata : m0_wdata;
    end
    if (mem_ren) begin
      mem_raddr = r_sel ? m1_addr : m0_addr;
    end
  end

  // Next-state: pointer moves to the loser on a conflict; read tag follows mem_ren.
  always_comb begin
    rr_d           = (w_conf | r_conf) ? ~rr_q : rr_q;
    rd_tag_valid_d = mem_ren;
    rd_tag_owner_d = mem_ren & r_sel;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q           <= 1'b0;
      rd_tag_valid_q <= 1'b0;
      rd_tag_owner_q <= 1'b0;
    end else begin
      rr_q           <= rr_d;
      rd_tag_valid_q <= rd_tag_valid_d;
      rd_tag_owner_q <= rd_tag_owner_d;
    end
  end

  // Route the read response to its owner only; the other master sees zero.
  always_comb begin
    m0_rvalid = rd_tag_valid_q & ~rd_tag_owner_q;
    m1_rvalid = rd_tag_valid_q & rd_tag_owner_q;
    m0_rdata  = m0_rvalid ? mem_rdata : '0;
    m1_rdata  = m1_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_dual_port_arbiter.sv
// Directed bench for mem_dual_port_arbiter. A small memory model with
// write-to-read forwarding sits on the memory ports. Read expectations are
// queued when a read is issued; a monitor pops them whenever an rvalid appears.
module tb_mem_dual_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_wen, mem_ren;
  logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] tbmem [16];

  mem_dual_port_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_wen   (mem_wen),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: preloaded with 0x1000_0000 + addr on clock edges in reset,
  // registered read, write data forwarded on a same-address collision.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) tbmem[i] <= 32'h1000_0000 + i;
      mem_rdata <= '0;
    end else begin
      if (mem_ren)
        mem_rdata <= (mem_wen && mem_waddr == mem_raddr) ? mem_wdata : tbmem[mem_raddr[3:0]];
      if (mem_wen) tbmem[mem_waddr[3:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rvalid must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m0_rvalid || m1_rvalid) begin
        checks++;
        if (m0_rvalid && m1_rvalid) begin
          errors++;
          $display("FAIL rvalid_both: m0_rvalid=1 m1_rvalid=1 expected at most one");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rvalid_spurious: m0_rvalid=%0b m1_rvalid=%0b expected none",
                   m0_rvalid, m1_rvalid);
        end else begin
          e = exp_q.pop_front();
          if (m1_rvalid !== e.owner) begin
            errors++;
            $display("FAIL rsp_owner: got m%0d expected m%0d", m1_rvalid, e.owner);
          end else if ((e.owner ? m1_rdata : m0_rdata) !== e.data) begin
            errors++;
            $display("FAIL rsp_data: got %h expected %h",
                     e.owner ? m1_rdata : m0_rdata, e.data);
          end else if ((e.owner ? m0_rdata : m1_rdata) !== 32'h0) begin
            errors++;
            $display("FAIL rsp_nonowner: got %h expected 00000000",
                     e.owner ? m0_rdata : m1_rdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    logic [31:0] t6_data [8];
    logic [3:0]  t2_gnt0;
    t6_data = '{32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h0000_000B,
                32'h1000_0004, 32'hDEAD_BEEF, 32'h1000_0006, 32'h1234_5678};
    t2_gnt0 = 4'b0101;  // bit i: M0 wins conflict cycle i

    // Reset with a pending request: grants and ports must stay forced off.
    rst_n = 1'b0;
    set_m0(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("rst_mem_ren", {31'd0, mem_ren}, 32'd0);
    chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    rst_n = 1'b1;

    // Test 1: M0 write then read back addr 5.
    @(negedge clk);
    chk("t1_wr_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    chk("t1_mem_wen", {30'd0, mem_ren, mem_wen}, 32'd1);
    chk("t1_waddr", mem_waddr, 32'd5);
    chk("t1_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    set_m0(1'b1, 1'b0, 32'd5, 32'd0);
    @(negedge clk);
    chk("t1_rd_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    chk("t1_raddr", mem_raddr, 32'd5);
    chk("t1_unused_waddr", mem_waddr, 32'd0);
    exp_q.push_back('{owner: 1'b0, data: 32'hDEAD_BEEF});
    next_cycle();
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    next_cycle();

    // Test 2: both read every cycle; grants alternate M0, M1, M0, M1.
    set_m0(1'b1, 1'b0, 32'd1, 32'd0);
    set_m1(1'b1, 1'b0, 32'd2, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_gnt", {30'd0, m1_gnt, m0_gnt}, t2_gnt0[i] ? 32'd1 : 32'd2);
      chk("t2_raddr", mem_raddr, t2_gnt0[i] ? 32'd1 : 32'd2);
      exp_q.push_back(t2_gnt0[i] ? '{owner: 1'b0, data: 32'h1000_0001}
                                 : '{owner: 1'b1, data: 32'h1000_0002});
      next_cycle();
    end
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    next_cycle();

    // Test 3: same-address write (M0) and read (M1); forwarded data to M1.
    set_m0(1'b1, 1'b1, 32'd7, 32'h1234_5678);
    set_m1(1'b1, 1'b0, 32'd7, 32'd0);
    @(negedge clk);
    chk("t3_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd3);
    chk("t3_ports", {30'd0, mem_ren, mem_wen}, 32'd3);
    chk("t3_raddr", mem_raddr, 32'd7);
    exp_q.push_back('{owner: 1'b1, data: 32'h1234_5678});
    next_cycle();
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    next_cycle();

    // Test 4: write conflict on addr 3; M0 first, M1 next; readback is 0xB.
    set_m0(1'b1, 1'b1, 32'd3, 32'hA);
    set_m1(1'b1, 1'b1, 32'd3, 32'hB);
    @(negedge clk);
    chk("t4_gnt_first", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    chk("t4_wdata_first", mem_wdata, 32'hA);
    next_cycle();
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("t4_gnt_second", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    chk("t4_wdata_second", mem_wdata, 32'hB);
    next_cycle();
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    set_m0(1'b1, 1'b0, 32'd3, 32'd0);
    @(negedge clk);
    chk("t4_rd_gnt", {31'd0, m0_gnt}, 32'd1);
    exp_q.push_back('{owner: 1'b0, data: 32'h0000_000B});
    next_cycle();
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    next_cycle();

    // Test 5: M1 read in flight, reset pulse drops it; first conflict goes to M0.
    set_m1(1'b1, 1'b0, 32'd4, 32'd0);
    @(negedge clk);
    chk("t5_m1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    next_cycle();
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    chk("t5_inflight", {30'd0, m1_rvalid, m0_rvalid}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("t5_rst_rdata", m1_rdata, 32'd0);
    #1 rst_n = 1'b1;
    set_m0(1'b1, 1'b0, 32'd1, 32'd0);
    set_m1(1'b1, 1'b0, 32'd2, 32'd0);
    @(negedge clk);
    chk("t5_conflict_m0", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    exp_q.push_back('{owner: 1'b0, data: 32'h1000_0001});
    next_cycle();
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("t5_then_m1", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    exp_q.push_back('{owner: 1'b1, data: 32'h1000_0002});
    next_cycle();
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    next_cycle();

    // Test 6: M0 streams reads of addr 0..7 at full throughput.
    for (int i = 0; i < 8; i++) begin
      set_m0(1'b1, 1'b0, i, 32'd0);
      @(negedge clk);
      chk("t6_gnt", {31'd0, m0_gnt}, 32'd1);
      if (i > 0) chk("t6_rvalid_stream", {31'd0, m0_rvalid}, 32'd1);
      exp_q.push_back('{owner: 1'b0, data: t6_data[i]});
      next_cycle();
    end
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("t6_rvalid_last", {31'd0, m0_rvalid}, 32'd1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("idle_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
